gun_shot_ctrl: RTL
==================

GUN_SHOT_CTRL -- requirements
Module: gun_shot_ctrl

Interface
REQ-001 Parameter STEP, default 15, gun displacement per frame tick in pixels.
REQ-002 Parameter XMIN, default 20, and XMAX, default 620, are the inclusive gun x limits.
REQ-003 Parameter Y0, default 440, is the bullet launch row; BSTEP, default 8, is bullet rise per frame tick.
REQ-004 Parameter COOLDOWN, default 8, is the number of frame ticks between bullet end and next allowed launch.
REQ-005 clk  input  1  single system clock; all state updates on posedge clk.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 frame_tick  input  1  one-cycle pulse per video frame; all motion steps occur only on this pulse.
REQ-008 bDer / bIzq  input  1 each  asynchronous right / left buttons, active-high.
REQ-009 bFire  input  1  asynchronous fire button, active-high.
REQ-010 hit  input  1  collision flag from playfield logic, sampled every cycle.
REQ-011 gunx  output  10  gun x position.
REQ-012 bullet_x / bullet_y  output  10 each  bullet position.
REQ-013 bullet_active  output  1  high exactly while state is FLY.
REQ-014 shot_fired  output  1  one-cycle pulse on launch.

Function
REQ-015 bDer, bIzq, bFire SHALL each pass a 2-flop synchroniser before any use; button effects lag the pin by 2 cycles.
REQ-016 Movement: on frame_tick, right-only gives gunx = min(gunx+STEP, XMAX); left-only gives gunx = max(gunx-STEP, XMIN); both or neither gives no change.
REQ-017 Saturation arithmetic SHALL be performed at 11 bits so gunx never wraps and never leaves [XMIN, XMAX].
REQ-018 A rising edge of synchronised bFire SHALL set an internal fire_req flag; holding bFire SHALL NOT set it again.
REQ-019 fire_req SHALL be cleared on every frame_tick, whether consumed or dropped.
REQ-020 States: IDLE, FLY, HIT.
REQ-021 IDLE -> FLY on frame_tick when fire_req=1 and cooldown=0: bullet_x <= gunx (pre-move value), bullet_y <= Y0, shot_fired=1 that cycle.
REQ-022 IDLE with cooldown>0: cooldown decrements by 1 on each frame_tick; fire_req on the same tick is dropped.
REQ-023 FLY on frame_tick without hit: if bullet_y < BSTEP, go to IDLE and load cooldown=COOLDOWN; else bullet_y <= bullet_y - BSTEP.
REQ-024 FLY with hit=1 in any cycle goes to HIT; hit takes priority over a coincident frame_tick, and bullet_y is not updated.
REQ-025 HIT: bullet_active=0; on next frame_tick go to IDLE with cooldown=COOLDOWN; further hit pulses are ignored.
REQ-026 hit in IDLE or HIT SHALL have no effect.
REQ-027 bullet_x SHALL stay constant during FLY regardless of gun motion.
REQ-028 Gun movement and bullet sequencing SHALL both act on the same frame_tick without interfering.

Reset
REQ-029 On rst_n=0, immediately: gunx=310, bullet_x=0, bullet_y=0, state=IDLE, cooldown=0, fire_req=0, synchronisers=0, shot_fired=0, bullet_active=0.
REQ-030 Reset asserted mid-flight SHALL abort the bullet with no shot_fired or cooldown carry-over after release.

Verification
REQ-031 Right held for 30 ticks from reset -> gunx 325, 340, ..., 610, then 620, held at 620; never exceeds 620.
REQ-032 bDer and bIzq both held for 5 ticks -> gunx stays at 310.
REQ-033 Fire pulse then tick -> one shot_fired pulse, bullet_x=310, bullet_y=440; after 55 ticks bullet_y=0; next tick: bullet_active=0, IDLE, cooldown=8.
REQ-034 Fire 3 ticks after bullet ends -> no launch; fire after 8 ticks of cooldown -> launch occurs.
REQ-035 hit coincident with frame_tick at bullet_y=400 -> HIT, bullet_y stays 400, bullet_active=0; IDLE on next tick.
REQ-036 rst_n pulled low asynchronously during FLY, between clock edges -> all outputs reset values before next clk edge.

Source files
------------

// File: rtl/gun_shot_ctrl.sv
// Gun position and single-bullet sequencer; buttons act 2 cycles after the pin, motion only on frame_tick.
// No backpressure: shot_fired is combinational in the launch cycle, all other outputs are registered.
module gun_shot_ctrl #(
    parameter int STEP     = 15,
    parameter int XMIN     = 20,
    parameter int XMAX     = 620,
    parameter int Y0       = 440,
    parameter int BSTEP    = 8,
    parameter int COOLDOWN = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       bDer,
    input  logic       bIzq,
    input  logic       bFire,
    input  logic       hit,
    output logic [9:0] gunx,
    output logic [9:0] bullet_x,
    output logic [9:0] bullet_y,
    output logic       bullet_active,
    output logic       shot_fired
);

    localparam int          CW      = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic [9:0]  GUN_RST = 10'd310;

    typedef enum logic [1:0] {IDLE, FLY, HIT} state_t;

    state_t          state, state_nxt;
    logic [2:0]      sync1, sync2;   // {fire, left, right}
    logic            fire_d;
    logic            fire_req;
    logic [CW-1:0]   cooldown;
    logic            right, left, fire_rise;
    logic [10:0]     gun_wide, gun_up, gun_dn;
    logic [9:0]      gun_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            fire_d <= 1'b0;
        end else begin
            sync1  <= {bFire, bIzq, bDer};
            sync2  <= sync1;
            fire_d <= sync2[2];
        end
    end

    assign right     = sync2[0] & ~sync2[1];
    assign left      = sync2[1] & ~sync2[0];
    assign fire_rise = sync2[2] & ~fire_d;

    // Saturating step at 11 bits; bit 10 of gun_dn flags an underflow below zero.
    always_comb begin
        gun_wide = {1'b0, gunx};
        gun_up   = gun_wide + 11'(STEP);
        gun_dn   = gun_wide - 11'(STEP);
        gun_nxt  = gunx;
        if (right)
            gun_nxt = (gun_up > 11'(XMAX)) ? 10'(XMAX) : gun_up[9:0];
        else if (left)
            gun_nxt = (gun_dn[10] || gun_dn < 11'(XMIN)) ? 10'(XMIN) : gun_dn[9:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (frame_tick && fire_req && cooldown == '0) state_nxt = FLY;
            FLY: begin
                if (hit)                                    state_nxt = HIT;
                else if (frame_tick && bullet_y < 10'(BSTEP)) state_nxt = IDLE;
            end
            HIT:  if (frame_tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bullet_active = (state == FLY);
        shot_fired    = (state == IDLE) && frame_tick && fire_req && (cooldown == '0);
    end

    // A fire edge landing on the same cycle as frame_tick is lost: the tick clears fire_req.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gunx     <= GUN_RST;
            bullet_x <= '0;
            bullet_y <= '0;
            fire_req <= 1'b0;
            cooldown <= '0;
        end else begin
            if (frame_tick) gunx <= gun_nxt;

            if (frame_tick)     fire_req <= 1'b0;
            else if (fire_rise) fire_req <= 1'b1;

            case (state)
                IDLE: begin
                    if (frame_tick) begin
                        if (cooldown != '0) begin
                            cooldown <= cooldown - 1'b1;
                        end else if (fire_req) begin
                            bullet_x <= gunx;
                            bullet_y <= 10'(Y0);
                        end
                    end
                end
                FLY: begin
                    if (!hit && frame_tick) begin
                        if (bullet_y < 10'(BSTEP)) cooldown <= CW'(COOLDOWN);
                        else                       bullet_y <= bullet_y - 10'(BSTEP);
                    end
                end
                HIT: begin
                    if (frame_tick) cooldown <= CW'(COOLDOWN);
                end
                default: ;
            endcase
        end
    end

endmodule
